// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined RV32I control unit.
// Decodes in ID, carries controls to WB, resolves hazards and forwarding.
module ctrl_pipe #(
   parameter int RFIDX_WIDTH   = 5,
   parameter bit EN_FWD        = 1'b1,
   parameter int ALUCTRL_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic [6:0]               funct7,
   input  logic [RFIDX_WIDTH-1:0]   rd,
   input  logic [RFIDX_WIDTH-1:0]   rs1,
   input  logic [RFIDX_WIDTH-1:0]   rs2,
   input  logic                     zero,
   input  logic                     lt,
   input  logic                     ext_stall,
   output logic [4:0]               immctrl,
   output logic                     bunsigned,
   output logic                     illegal,
   output logic                     stall,
   output logic                     flush_ifid,
   output logic                     pcsrc,
   output logic                     jalr,
   output logic [ALUCTRL_WIDTH-1:0] ex_aluctrl,
   output logic [1:0]               ex_alusrca,
   output logic                     ex_alusrcb,
   output logic [1:0]               fwd_a,
   output logic [1:0]               fwd_b,
   output logic                     mem_memwrite,
   output logic [1:0]               mem_swhb,
   output logic [1:0]               mem_lwhb,
   output logic                     mem_lunsigned,
   output logic                     wb_memtoreg,
   output logic                     wb_regwrite,
   output logic [RFIDX_WIDTH-1:0]   wb_rd
);

   typedef struct packed {
      logic [ALUCTRL_WIDTH-1:0] aluctrl;
      logic [1:0]               alusrca;
      logic                     alusrcb;
      logic                     memwrite;
      logic [1:0]               swhb;
      logic [1:0]               lwhb;
      logic                     lunsigned;
      logic                     memtoreg;
      logic                     regwrite;
      logic [RFIDX_WIDTH-1:0]   rd;
      logic [RFIDX_WIDTH-1:0]   rs1;
      logic [RFIDX_WIDTH-1:0]   rs2;
   } ex_t;

   typedef struct packed {
      logic                   memwrite;
      logic [1:0]             swhb;
      logic [1:0]             lwhb;
      logic                   lunsigned;
      logic                   memtoreg;
      logic                   regwrite;
      logic [RFIDX_WIDTH-1:0] rd;
   } mem_t;

   typedef struct packed {
      logic                   memtoreg;
      logic                   regwrite;
      logic [RFIDX_WIDTH-1:0] rd;
   } wb_t;

   ex_t  id_b;
   ex_t  ex_d,  ex_q;
   mem_t mem_d, mem_q;
   wb_t  wb_d,  wb_q;

   logic is_lui, is_auipc, is_jal, is_jalr;
   logic is_br, is_ld, is_st, is_opi, is_op;
   logic dec_ok, id_ok, use1, use2, wr_en, alt;
   logic ex_hit, mem_hit, load_use, raw, br_hz;
   logic hazard, taken;

   assign is_lui   = (opcode == 7'b0110111);
   assign is_auipc = (opcode == 7'b0010111);
   assign is_jal   = (opcode == 7'b1101111);
   assign is_jalr  = (opcode == 7'b1100111)
                   && (funct3 == 3'b000);
   assign is_br    = (opcode == 7'b1100011)
                   && (funct3[2:1] != 2'b01);
   assign is_ld    = (opcode == 7'b0000011)
                   && (funct3 != 3'b011)
                   && (funct3[2:1] != 2'b11);
   assign is_st    = (opcode == 7'b0100011)
                   && (funct3[2] == 1'b0)
                   && (funct3[1:0] != 2'b11);
   assign is_opi   = (opcode == 7'b0010011)
                   && ((funct3 == 3'b001) ? (funct7 == 7'b0)
                   : (funct3 == 3'b101)
                     ? (funct7 == 7'b0 || funct7 == 7'b0100000)
                   : 1'b1);
   assign is_op    = (opcode == 7'b0110011)
                   && ((funct7 == 7'b0)
                   || (funct7 == 7'b0100000
                       && funct3[1:0] == 2'b00
                       && funct3[2] == 1'b0)
                   || (funct7 == 7'b0100000
                       && funct3 == 3'b101));

   assign dec_ok = is_lui | is_auipc | is_jal | is_jalr
                 | is_br | is_ld | is_st | is_opi | is_op;
   assign id_ok   = id_valid & dec_ok;
   assign illegal = id_valid & ~dec_ok;
   assign use1 = id_ok & ~(is_lui | is_auipc | is_jal);
   assign use2 = id_ok & (is_br | is_st | is_op);
   assign wr_en = id_ok & (rd != '0)
                & (is_lui | is_auipc | is_jal | is_jalr
                   | is_ld | is_opi | is_op);
   assign alt = is_op ? funct7[5]
              : (funct3 == 3'b101) & funct7[5];
   assign bunsigned = is_br & funct3[1];

   // ID decode into the control bundle handed to ID/EX
   always_comb begin
      id_b    = '0;
      immctrl = '0;
      unique case (1'b1)
         is_lui: begin
            immctrl      = 5'b00010;
            id_b.alusrca = 2'b01;
            id_b.alusrcb = 1'b1;
         end
         is_auipc: begin
            immctrl      = 5'b00010;
            id_b.alusrca = 2'b10;
            id_b.alusrcb = 1'b1;
         end
         is_jal: begin
            immctrl      = 5'b00001;
            id_b.alusrca = 2'b10;
            id_b.alusrcb = 1'b1;
         end
         is_jalr: begin
            immctrl      = 5'b10000;
            id_b.alusrcb = 1'b1;
         end
         is_br: begin
            immctrl      = 5'b00100;
            id_b.aluctrl = ALUCTRL_WIDTH'(4'b1000);
         end
         is_ld: begin
            immctrl        = 5'b10000;
            id_b.alusrcb   = 1'b1;
            id_b.memtoreg  = 1'b1;
            id_b.lunsigned = funct3[2];
            id_b.lwhb      = (funct3[1:0] == 2'b00) ? 2'b10
                           : (funct3[1:0] == 2'b01) ? 2'b01
                           : 2'b00;
         end
         is_st: begin
            immctrl       = 5'b01000;
            id_b.alusrcb  = 1'b1;
            id_b.memwrite = 1'b1;
            id_b.swhb     = 2'b11 - funct3[1:0];
         end
         is_opi: begin
            immctrl      = 5'b10000;
            id_b.alusrcb = 1'b1;
            id_b.aluctrl = ALUCTRL_WIDTH'({alt, funct3});
         end
         is_op: begin
            id_b.aluctrl = ALUCTRL_WIDTH'({alt, funct3});
         end
         default: ;
      endcase
      if (!id_ok) begin
         id_b = '0;
      end
      id_b.regwrite = wr_en;
      id_b.rd  = wr_en ? rd  : '0;
      id_b.rs1 = use1  ? rs1 : '0;
      id_b.rs2 = use2  ? rs2 : '0;
   end

   // hazard detection and redirect for the instruction in ID
   always_comb begin
      ex_hit  = ex_q.regwrite
              & ((use1 & (ex_q.rd == rs1))
              |  (use2 & (ex_q.rd == rs2)));
      mem_hit = mem_q.regwrite
              & ((use1 & (mem_q.rd == rs1))
              |  (use2 & (mem_q.rd == rs2)));
      load_use = ex_hit & ex_q.memtoreg;
      raw      = EN_FWD ? 1'b0 : (ex_hit | mem_hit);
      br_hz    = (is_br | is_jalr)
               & (ex_hit | (mem_hit & mem_q.memtoreg));
      hazard   = load_use | raw | br_hz;
      taken    = is_jal | is_jalr
               | (is_br & (funct3[2] ? (lt ^ funct3[0])
                                     : (zero ^ funct3[0])));
      stall      = hazard & ~ext_stall;
      pcsrc      = id_ok & taken & ~hazard & ~ext_stall;
      flush_ifid = pcsrc;
      jalr       = id_ok & is_jalr;
   end

   // stage advance: freeze on ext_stall, bubble into EX on hazard
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!ext_stall) begin
         if (hazard) begin
            ex_d = '0;
         end else begin
            ex_d = id_b;
         end
         mem_d.memwrite  = ex_q.memwrite;
         mem_d.swhb      = ex_q.swhb;
         mem_d.lwhb      = ex_q.lwhb;
         mem_d.lunsigned = ex_q.lunsigned;
         mem_d.memtoreg  = ex_q.memtoreg;
         mem_d.regwrite  = ex_q.regwrite;
         mem_d.rd        = ex_q.rd;
         wb_d.memtoreg   = mem_q.memtoreg;
         wb_d.regwrite   = mem_q.regwrite;
         wb_d.rd         = mem_q.rd;
      end
   end

   // pipeline registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // EX operand forwarding, MEM result preferred over WB
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (EN_FWD) begin
         if (mem_q.regwrite && !mem_q.memtoreg
             && mem_q.rd != '0 && mem_q.rd == ex_q.rs1)
            fwd_a = 2'b01;
         else if (wb_q.regwrite && wb_q.rd != '0
                  && wb_q.rd == ex_q.rs1)
            fwd_a = 2'b10;
         if (mem_q.regwrite && !mem_q.memtoreg
             && mem_q.rd != '0 && mem_q.rd == ex_q.rs2)
            fwd_b = 2'b01;
         else if (wb_q.regwrite && wb_q.rd != '0
                  && wb_q.rd == ex_q.rs2)
            fwd_b = 2'b10;
      end
   end

   assign ex_aluctrl    = ex_q.aluctrl;
   assign ex_alusrca    = ex_q.alusrca;
   assign ex_alusrcb    = ex_q.alusrcb;
   assign mem_memwrite  = mem_q.memwrite;
   assign mem_swhb      = mem_q.swhb;
   assign mem_lwhb      = mem_q.lwhb;
   assign mem_lunsigned = mem_q.lunsigned;
   assign wb_memtoreg   = wb_q.memtoreg;
   assign wb_regwrite   = wb_q.regwrite;
   assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus randomized run
// against an instruction-level pipeline model.
module tb_ctrl_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd, rs1, rs2;
   logic       zero, lt, ext_stall;

   logic [4:0] immctrl, n_immctrl;
   logic       bunsigned, n_bunsigned;
   logic       illegal, n_illegal;
   logic       stall, n_stall;
   logic       flush_ifid, n_flush_ifid;
   logic       pcsrc, n_pcsrc;
   logic       jalr, n_jalr;
   logic [3:0] ex_aluctrl, n_ex_aluctrl;
   logic [1:0] ex_alusrca, n_ex_alusrca;
   logic       ex_alusrcb, n_ex_alusrcb;
   logic [1:0] fwd_a, n_fwd_a;
   logic [1:0] fwd_b, n_fwd_b;
   logic       mem_memwrite, n_mem_memwrite;
   logic [1:0] mem_swhb, n_mem_swhb;
   logic [1:0] mem_lwhb, n_mem_lwhb;
   logic       mem_lunsigned, n_mem_lunsigned;
   logic       wb_memtoreg, n_wb_memtoreg;
   logic       wb_regwrite, n_wb_regwrite;
   logic [4:0] wb_rd, n_wb_rd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ctrl_pipe #(.RFIDX_WIDTH(5), .EN_FWD(1'b1),
               .ALUCTRL_WIDTH(4)) u_fwd (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .zero(zero), .lt(lt),
      .ext_stall(ext_stall), .immctrl(immctrl),
      .bunsigned(bunsigned), .illegal(illegal),
      .stall(stall), .flush_ifid(flush_ifid),
      .pcsrc(pcsrc), .jalr(jalr), .ex_aluctrl(ex_aluctrl),
      .ex_alusrca(ex_alusrca), .ex_alusrcb(ex_alusrcb),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_memwrite(mem_memwrite), .mem_swhb(mem_swhb),
      .mem_lwhb(mem_lwhb), .mem_lunsigned(mem_lunsigned),
      .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
      .wb_rd(wb_rd));

   ctrl_pipe #(.RFIDX_WIDTH(5), .EN_FWD(1'b0),
               .ALUCTRL_WIDTH(4)) u_nofwd (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .zero(zero), .lt(lt),
      .ext_stall(ext_stall), .immctrl(n_immctrl),
      .bunsigned(n_bunsigned), .illegal(n_illegal),
      .stall(n_stall), .flush_ifid(n_flush_ifid),
      .pcsrc(n_pcsrc), .jalr(n_jalr),
      .ex_aluctrl(n_ex_aluctrl),
      .ex_alusrca(n_ex_alusrca), .ex_alusrcb(n_ex_alusrcb),
      .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
      .mem_memwrite(n_mem_memwrite), .mem_swhb(n_mem_swhb),
      .mem_lwhb(n_mem_lwhb), .mem_lunsigned(n_mem_lunsigned),
      .wb_memtoreg(n_wb_memtoreg),
      .wb_regwrite(n_wb_regwrite), .wb_rd(n_wb_rd));

   typedef enum int {
      K_NOP, K_LUI, K_AUIPC, K_JAL, K_JALR,
      K_BR, K_LD, K_ST, K_OPI, K_OP
   } kind_e;

   typedef struct {
      kind_e k;
      int    rd;
      int    rs1;
      int    rs2;
      int    f3;
      bit    alt;
   } ins_t;

   function automatic ins_t mk(kind_e k, int d, int s1,
                               int s2, int f3, bit alt);
      ins_t i;
      i.k = k; i.rd = d; i.rs1 = s1; i.rs2 = s2;
      i.f3 = f3; i.alt = alt;
      return i;
   endfunction

   function automatic ins_t nop();
      return mk(K_NOP, 0, 0, 0, 0, 1'b0);
   endfunction

   task automatic drive(input ins_t i);
      id_valid = (i.k != K_NOP);
      rd  = 5'(i.rd);
      rs1 = 5'(i.rs1);
      rs2 = 5'(i.rs2);
      funct3 = 3'(i.f3);
      funct7 = i.alt ? 7'b0100000 : 7'b0000000;
      case (i.k)
         K_LUI:   opcode = 7'b0110111;
         K_AUIPC: opcode = 7'b0010111;
         K_JAL:   opcode = 7'b1101111;
         K_JALR:  opcode = 7'b1100111;
         K_BR:    opcode = 7'b1100011;
         K_LD:    opcode = 7'b0000011;
         K_ST:    opcode = 7'b0100011;
         K_OP:    opcode = 7'b0110011;
         default: opcode = 7'b0010011;
      endcase
   endtask

   function automatic bit writes(ins_t i);
      return (i.k inside {K_LUI, K_AUIPC, K_JAL, K_JALR,
                          K_LD, K_OPI, K_OP}) && i.rd != 0;
   endfunction

   function automatic bit use1(ins_t i);
      return i.k inside {K_JALR, K_BR, K_LD, K_ST,
                         K_OPI, K_OP};
   endfunction

   function automatic bit use2(ins_t i);
      return i.k inside {K_BR, K_ST, K_OP};
   endfunction

   function automatic bit hits(ins_t p, ins_t i);
      return writes(p)
         && ((use1(i) && p.rd == i.rs1)
          || (use2(i) && p.rd == i.rs2));
   endfunction

   function automatic bit taken(ins_t i, bit z, bit l);
      if (i.k == K_JAL || i.k == K_JALR) return 1'b1;
      if (i.k != K_BR) return 1'b0;
      case (i.f3)
         0: return z;
         1: return !z;
         4, 6: return l;
         default: return !l;
      endcase
   endfunction

   function automatic logic [1:0] fsel(ins_t e, bit second,
                                       ins_t m, ins_t w);
      bit used;
      int src;
      used = second ? use2(e) : use1(e);
      src  = second ? e.rs2 : e.rs1;
      if (!used || src == 0) return 2'b00;
      if (writes(m) && m.k != K_LD && m.rd == src)
         return 2'b01;
      if (writes(w) && w.rd == src) return 2'b10;
      return 2'b00;
   endfunction

   function automatic ins_t rnd();
      ins_t i;
      int bf[6] = '{0, 1, 4, 5, 6, 7};
      int lf[5] = '{0, 1, 2, 4, 5};
      i = mk(kind_e'($urandom_range(0, 9)),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
      case (i.k)
         K_JALR: i.f3 = 0;
         K_BR:   i.f3 = bf[$urandom_range(0, 5)];
         K_LD:   i.f3 = lf[$urandom_range(0, 4)];
         K_ST:   i.f3 = $urandom_range(0, 2);
         K_OPI:  i.alt = (i.f3 == 5) && ($urandom_range(0, 1) == 1);
         K_OP:   i.alt = (i.f3 == 0 || i.f3 == 5)
                         && ($urandom_range(0, 1) == 1);
         default: ;
      endcase
      return i;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      ext_stall = 1'b0;
      zero = 1'b0;
      lt = 1'b0;
      drive(nop());
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ext_stall = 1'b0;
      zero = 1'b0;
      lt = 1'b0;
      drive(nop());
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if ({ex_aluctrl, ex_alusrca, ex_alusrcb} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ex got=%b exp=0",
                  {ex_aluctrl, ex_alusrca, ex_alusrcb});
      end
      total++;
      if ({mem_memwrite, mem_swhb, mem_lwhb, mem_lunsigned}
          !== 6'b0) begin
         bad++;
         $display("FAIL reset_mem got=%b exp=0",
                  {mem_memwrite, mem_swhb, mem_lwhb,
                   mem_lunsigned});
      end
      total++;
      if ({wb_memtoreg, wb_regwrite, wb_rd} !== 7'b0) begin
         bad++;
         $display("FAIL reset_wb got=%b exp=0",
                  {wb_memtoreg, wb_regwrite, wb_rd});
      end
      total++;
      if ({fwd_a, fwd_b, stall, pcsrc} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctl got=%b exp=0",
                  {fwd_a, fwd_b, stall, pcsrc});
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load_use();
      do_reset();
      drive(mk(K_LD, 5, 1, 0, 2, 1'b0));
      @(negedge clk);
      drive(mk(K_OP, 6, 5, 7, 0, 1'b0));
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL lu_stall got=%b exp=1", stall);
      end
      @(negedge clk);
      #1;
      total++;
      if (stall !== 1'b0 || ex_alusrcb !== 1'b0) begin
         bad++;
         $display("FAIL lu_bubble stall=%b srcb=%b exp=0,0",
                  stall, ex_alusrcb);
      end
      @(negedge clk);
      drive(nop());
      #1;
      total++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
         bad++;
         $display("FAIL lu_fwd got=%b/%b exp=10/00",
                  fwd_a, fwd_b);
      end
      total++;
      if ({wb_memtoreg, wb_regwrite, wb_rd} !== 7'b1100101) begin
         bad++;
         $display("FAIL lu_wb got=%b exp=1100101",
                  {wb_memtoreg, wb_regwrite, wb_rd});
      end
      @(negedge clk);
   endtask

   task automatic test_fwd();
      do_reset();
      drive(mk(K_OPI, 5, 0, 3, 0, 1'b0));
      @(negedge clk);
      drive(mk(K_OP, 6, 5, 5, 0, 1'b0));
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL fwd_nostall got=%b exp=0", stall);
      end
      @(negedge clk);
      drive(nop());
      #1;
      total++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
         bad++;
         $display("FAIL fwd_mem got=%b/%b exp=01/01",
                  fwd_a, fwd_b);
      end
      @(negedge clk);
   endtask

   task automatic test_nofwd();
      int n;
      do_reset();
      drive(mk(K_OPI, 5, 0, 3, 0, 1'b0));
      @(negedge clk);
      drive(mk(K_OP, 6, 5, 5, 0, 1'b0));
      n = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (n_stall === 1'b1) n++;
         if (c == 2) begin
            total++;
            if (n_wb_regwrite !== 1'b1 || n_wb_rd !== 5'd5) begin
               bad++;
               $display("FAIL nofwd_wb got=%b/%0d exp=1/5",
                        n_wb_regwrite, n_wb_rd);
            end
         end
         @(negedge clk);
      end
      total++;
      if (n != 2) begin
         bad++;
         $display("FAIL nofwd_stalls got=%0d exp=2", n);
      end
      drive(nop());
      #1;
      total++;
      if (n_fwd_a !== 2'b00 || n_fwd_b !== 2'b00
          || n_ex_aluctrl !== 4'b0000) begin
         bad++;
         $display("FAIL nofwd_ex fwd=%b/%b alu=%b exp=00/00/0",
                  n_fwd_a, n_fwd_b, n_ex_aluctrl);
      end
      @(negedge clk);
   endtask

   task automatic test_branch();
      do_reset();
      zero = 1'b1;
      drive(mk(K_BR, 0, 1, 2, 0, 1'b0));
      #1;
      total++;
      if (pcsrc !== 1'b1 || flush_ifid !== 1'b1
          || immctrl !== 5'b00100) begin
         bad++;
         $display("FAIL beq pc=%b fl=%b imm=%b exp=1/1/00100",
                  pcsrc, flush_ifid, immctrl);
      end
      @(negedge clk);
      drive(mk(K_BR, 0, 1, 2, 1, 1'b0));
      #1;
      total++;
      if (pcsrc !== 1'b0 || flush_ifid !== 1'b0) begin
         bad++;
         $display("FAIL bne got=%b/%b exp=0/0",
                  pcsrc, flush_ifid);
      end
      @(negedge clk);
      zero = 1'b0;
      lt = 1'b1;
      drive(mk(K_BR, 0, 1, 2, 7, 1'b0));
      #1;
      total++;
      if (pcsrc !== 1'b0 || bunsigned !== 1'b1) begin
         bad++;
         $display("FAIL bgeu pc=%b uns=%b exp=0/1",
                  pcsrc, bunsigned);
      end
      @(negedge clk);
      drive(mk(K_JALR, 1, 3, 0, 0, 1'b0));
      #1;
      total++;
      if (pcsrc !== 1'b1 || jalr !== 1'b1
          || immctrl !== 5'b10000) begin
         bad++;
         $display("FAIL jalr pc=%b j=%b imm=%b exp=1/1/10000",
                  pcsrc, jalr, immctrl);
      end
      @(negedge clk);
   endtask

   task automatic test_branch_hazard();
      do_reset();
      drive(mk(K_OPI, 1, 0, 4, 0, 1'b0));
      @(negedge clk);
      zero = 1'b1;
      drive(mk(K_BR, 0, 1, 2, 0, 1'b0));
      #1;
      total++;
      if (stall !== 1'b1 || pcsrc !== 1'b0) begin
         bad++;
         $display("FAIL brhz_stall got=%b/%b exp=1/0",
                  stall, pcsrc);
      end
      @(negedge clk);
      #1;
      total++;
      if (stall !== 1'b0 || pcsrc !== 1'b1) begin
         bad++;
         $display("FAIL brhz_go got=%b/%b exp=0/1",
                  stall, pcsrc);
      end
      @(negedge clk);
      drive(mk(K_OPI, 0, 0, 5, 0, 1'b0));
      @(negedge clk);
      drive(mk(K_OP, 7, 0, 0, 0, 1'b0));
      @(negedge clk);
      drive(nop());
      #1;
      total++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         bad++;
         $display("FAIL x0_fwd got=%b/%b exp=00/00",
                  fwd_a, fwd_b);
      end
      @(negedge clk);
      #1;
      total++;
      if (wb_regwrite !== 1'b0 || wb_rd !== 5'd0) begin
         bad++;
         $display("FAIL x0_wb got=%b/%0d exp=0/0",
                  wb_regwrite, wb_rd);
      end
      @(negedge clk);
   endtask

   task automatic test_ext_stall();
      do_reset();
      drive(mk(K_LD, 5, 1, 0, 2, 1'b0));
      @(negedge clk);
      drive(mk(K_OP, 6, 5, 7, 0, 1'b0));
      ext_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (stall !== 1'b0 || pcsrc !== 1'b0
             || ex_alusrcb !== 1'b1 || wb_rd !== 5'd0
             || mem_memwrite !== 1'b0) begin
            bad++;
            $display("FAIL ext_frz c=%0d st=%b pc=%b srcb=%b wbrd=%0d",
                     c, stall, pcsrc, ex_alusrcb, wb_rd);
         end
         @(negedge clk);
      end
      ext_stall = 1'b0;
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL ext_resume got=%b exp=1", stall);
      end
      @(negedge clk);
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL ext_once got=%b exp=0", stall);
      end
      @(negedge clk);
      drive(nop());
      #1;
      total++;
      if (fwd_a !== 2'b10 || wb_rd !== 5'd5) begin
         bad++;
         $display("FAIL ext_fwd got=%b/%0d exp=10/5",
                  fwd_a, wb_rd);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(mk(K_LD, 5, 1, 0, 2, 1'b0));
      @(negedge clk);
      drive(mk(K_OP, 6, 5, 7, 0, 1'b0));
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (stall !== 1'b0 || ex_alusrcb !== 1'b0) begin
         bad++;
         $display("FAIL async_rst st=%b srcb=%b exp=0/0",
                  stall, ex_alusrcb);
      end
      id_valid = 1'b1;
      opcode = 7'b1111111;
      #1;
      total++;
      if (illegal !== 1'b1) begin
         bad++;
         $display("FAIL illegal_v got=%b exp=1", illegal);
      end
      id_valid = 1'b0;
      #1;
      total++;
      if (illegal !== 1'b0) begin
         bad++;
         $display("FAIL illegal_nv got=%b exp=0", illegal);
      end
      @(negedge clk);
      reset = 1'b1;
      drive(mk(K_OPI, 3, 1, 2, 1, 1'b1));
      #1;
      total++;
      if (illegal !== 1'b1 || stall !== 1'b0) begin
         bad++;
         $display("FAIL illegal_slli got=%b/%b exp=1/0",
                  illegal, stall);
      end
      @(negedge clk);
      drive(nop());
      #1;
      total++;
      if (ex_alusrcb !== 1'b0 || ex_aluctrl !== 4'b0) begin
         bad++;
         $display("FAIL illegal_bubble got=%b/%b exp=0/0",
                  ex_alusrcb, ex_aluctrl);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      ins_t idm, exm, memm, wbm;
      bit hz, est, epc, ext;
      logic [1:0] efa, efb;
      do_reset();
      idm = nop(); exm = nop(); memm = nop(); wbm = nop();
      for (int c = 0; c < 600; c++) begin
         ext = ($urandom_range(0, 7) == 0);
         ext_stall = ext;
         zero = 1'($urandom_range(0, 1));
         lt = 1'($urandom_range(0, 1));
         drive(idm);
         #1;
         hz = (exm.k == K_LD && hits(exm, idm))
           || ((idm.k == K_BR || idm.k == K_JALR)
               && (hits(exm, idm)
                   || (memm.k == K_LD && hits(memm, idm))));
         est = hz && !ext;
         epc = idm.k != K_NOP && taken(idm, zero, lt)
            && !hz && !ext;
         efa = fsel(exm, 1'b0, memm, wbm);
         efb = fsel(exm, 1'b1, memm, wbm);
         total++;
         if (stall !== est) begin
            bad++;
            $display("FAIL rnd_stall c=%0d got=%b exp=%b",
                     c, stall, est);
         end
         total++;
         if (pcsrc !== epc || flush_ifid !== epc) begin
            bad++;
            $display("FAIL rnd_pcsrc c=%0d got=%b/%b exp=%b",
                     c, pcsrc, flush_ifid, epc);
         end
         total++;
         if (fwd_a !== efa || fwd_b !== efb) begin
            bad++;
            $display("FAIL rnd_fwd c=%0d got=%b/%b exp=%b/%b",
                     c, fwd_a, fwd_b, efa, efb);
         end
         total++;
         if (wb_regwrite !== writes(wbm)
             || wb_rd !== (writes(wbm) ? 5'(wbm.rd) : 5'd0)
             || wb_memtoreg !== (wbm.k == K_LD)) begin
            bad++;
            $display("FAIL rnd_wb c=%0d got=%b/%0d/%b",
                     c, wb_regwrite, wb_rd, wb_memtoreg);
         end
         total++;
         if (mem_memwrite !== (memm.k == K_ST)) begin
            bad++;
            $display("FAIL rnd_memwr c=%0d got=%b exp=%b",
                     c, mem_memwrite, memm.k == K_ST);
         end
         if (!ext) begin
            wbm = memm;
            memm = exm;
            exm = hz ? nop() : idm;
         end
         if (!(ext || est)) idm = epc ? nop() : rnd();
         @(negedge clk);
      end
      ext_stall = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_use();
      test_fwd();
      test_nofwd();
      test_branch();
      test_branch_hazard();
      test_ext_stall();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle decode controller.
- Decodes full RV32I in ID, then carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and branch-operand hazards, generates stall, flush and redirect signals, and selects EX-stage operand forwarding.
- Sits between the IF/ID register and the datapath stage muxes.

Parameters:
RFIDX_WIDTH, 5, register index width
EN_FWD, 1, 1 = EX forwarding from MEM/WB; 0 = no forwarding, stall on every RAW hazard
ALUCTRL_WIDTH, 4, width of the ALU control code

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset; 0 clears all pipeline state
id_valid  in  1  IF/ID holds a real instruction
opcode  in  7  ID instruction opcode
funct3  in  3  ID funct3
funct7  in  7  ID funct7
rd  in  RFIDX_WIDTH  ID destination register
rs1  in  RFIDX_WIDTH  ID source register 1
rs2  in  RFIDX_WIDTH  ID source register 2
zero  in  1  ID comparator: rs1==rs2
lt  in  1  ID comparator: rs1<rs2 (signedness per bunsigned)
ext_stall  in  1  memory-system stall; freezes the whole pipeline
immctrl  out  5  ID immediate select {i,s,b,u,j}
bunsigned  out  1  ID comparator unsigned mode
illegal  out  1  ID instruction undecodable while id_valid=1
stall  out  1  hold PC and IF/ID
flush_ifid  out  1  squash IF/ID on redirect
pcsrc  out  1  redirect PC (taken branch, jal, jalr)
jalr  out  1  redirect target is register-based
ex_aluctrl  out  ALUCTRL_WIDTH  EX ALU operation
ex_alusrca  out  2  EX operand A select (00 rs1, 01 zero, 10 pc)
ex_alusrcb  out  1  EX operand B select (1 = immediate)
fwd_a  out  2  EX rs1 forward select (00 regfile, 01 EX/MEM, 10 MEM/WB)
fwd_b  out  2  EX rs2 forward select (same encoding as fwd_a)
mem_memwrite  out  1  MEM store enable
mem_swhb  out  2  MEM store size (01 word, 10 half, 11 byte)
mem_lwhb  out  2  MEM load size (00 word, 01 half, 10 byte)
mem_lunsigned  out  1  MEM load zero-extend
wb_memtoreg  out  1  WB selects load data
wb_regwrite  out  1  WB register write enable
wb_rd  out  RFIDX_WIDTH  WB destination register

Behaviour:
- Reset (reset=0, async): every pipeline register holds a bubble (all controls 0, rd 0); all registered outputs 0; fwd_a/fwd_b 00.
- Decode:
  - Covers lui, auipc, jal, jalr, branch, load, store, op-imm, op.
  - regwrite = lui|auipc|jal|jalr|load|op-imm|op, and is forced 0 when rd==0.
  - Source usage: rs1 used by all except lui/auipc/jal; rs2 used only by branch/store/op.
  - Undecodable encodings assert illegal and issue a bubble.
  - id_valid=0 is treated as a bubble.
- Stage advance: when stall=0 and ext_stall=0, each stage takes the previous one on posedge clk. Latency: ID→EX 1 cycle, ID→MEM 2 cycles, ID→WB 3 cycles.
- ext_stall=1 freezes all stages and suppresses pcsrc, flush_ifid and stall. It has priority over every other event.
- Load-use hazard: EX holds a load with rd≠0 and rd matches a used ID source.
  - stall=1; a bubble is inserted into ID/EX; ID is held.
  - Exactly 1 cycle when EN_FWD=1.
- EN_FWD=0: stall while any EX or MEM stage with regwrite has rd matching a used ID source. The regfile is write-before-read, so a WB-stage producer never stalls.
- Branch/jalr operand hazard (compare in ID): stall while EX has regwrite to a used source, or MEM holds a load to a used source.
- Redirect:
  - pcsrc=1 when ID is valid, unstalled and one of: jal; jalr; beq&zero; bne&!zero; blt/bltu&lt; bge/bgeu&!lt.
  - flush_ifid = pcsrc; same cycle, combinational.
  - The redirecting instruction itself proceeds to EX.
- Forwarding (EN_FWD=1), combinational from registered EX sources:
  - fwd_x=01 if MEM regwrite, non-load, rd≠0, rd==src.
  - Else 10 if WB regwrite, rd≠0, rd==src.
  - Else 00.
  - MEM has priority over WB.
  - With EN_FWD=0, fwd_a/fwd_b are tied to 00.
- Simultaneous load-use stall and branch in ID: the stall wins and pcsrc is held 0 until resolved.
- Reset asserted mid-stall: all state clears immediately; stall deasserts.

Test Plan:
- lw x5,0(x1) then add x6,x5,x7 → stall=1 for exactly 1 cycle, EX bubble, then fwd_a=10 for the add in EX.
- addi x5,x0,3 then add x6,x5,x5 (EN_FWD=1) → no stall, fwd_a=fwd_b=01. Repeat with EN_FWD=0 → stall 2 cycles, fwd 00.
- beq x1,x2 with zero=1, no hazards → pcsrc=1, flush_ifid=1 same cycle; bne with zero=1 → pcsrc=0.
- addi x1,.. followed by beq x1,x2 → stall 1 cycle, then pcsrc evaluated. addi x0,x0,5 → wb_regwrite=0 and never forwards.
- ext_stall=1 for 3 cycles during a load-use stall → all outputs frozen; sequence resumes identically after release.
- reset=0 asynchronously mid-pipeline (no clk edge) → all registered outputs 0 immediately; illegal=1 for opcode 1111111 with id_valid=1, and 0 when id_valid=0.
